fir_channel_scheduler: RTL and testbench
========================================

Name: fir_channel_scheduler

Overview:
Front-end controller for the multi-channel symmetric FIR. It merges N_CHANNELS independent AXI-Stream sources into the filter's single tid-tagged input stream using a round-robin arbiter. It also runs a coefficient-reload sequencer: it stalls input, drains the filter pipeline, then copies HALF_N coefficients from a shadow bank into the filter's coefficient write port.

Parameters:
N_CHANNELS, 4, number of input streams / tid values
DATA_WIDTH, 16, sample width
HALF_N, 16, coefficient words written per reload (N_TAPS/2)
TID_WIDTH, $clog2(N_CHANNELS), m_axis_tid width
COEFF_WIDTH, 16, coefficient width
COEFF_ADDR_WIDTH, $clog2(HALF_N), coefficient address width
DRAIN_CYCLES, 12, idle cycles after output empties before writing coefficients (filter latency 9 + margin)

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous, active-low
s_axis_tvalid  in  N_CHANNELS  per-channel valid
s_axis_tready  out  N_CHANNELS  per-channel ready
s_axis_tdata  in  N_CHANNELS*DATA_WIDTH  packed data; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
s_axis_tlast  in  N_CHANNELS  per-channel last
m_axis_tvalid  out  1  to filter s_axis_tvalid
m_axis_tready  in  1  from filter s_axis_tready
m_axis_tdata  out  DATA_WIDTH  merged sample
m_axis_tid  out  TID_WIDTH  source channel index
m_axis_tlast  out  1  forwarded tlast
reload_req  in  1  level request for a coefficient reload
reload_done  out  1  one-cycle pulse when the reload completes
shadow_rd_addr  out  COEFF_ADDR_WIDTH  shadow-bank read address
shadow_rd_data  in  COEFF_WIDTH  shadow-bank data, one-cycle read latency
coeff_wr_en  out  1  to filter coeff_wr_en
coeff_wr_addr  out  COEFF_ADDR_WIDTH  to filter coeff_wr_addr
coeff_wr_data  out  COEFF_WIDTH  to filter coeff_wr_data
sched_state  out  2  00 RUN, 01 DRAIN, 10 LOAD

Behaviour:
- Reset values: all s_axis_tready = 0, m_axis_tvalid = 0, tdata/tid/tlast = 0, reload_done = 0, coeff_wr_en = 0, addresses = 0, state = RUN, round-robin pointer = 0.
- Output stage: one register. slot_free = !m_axis_tvalid || m_axis_tready. Latency is 1 cycle from input acceptance to m_axis_tvalid. Output is held stable while tvalid=1 and tready=0.
- Arbitration (RUN only):
  - grant = first k with s_axis_tvalid[k], scanning from the pointer upward and wrapping modulo N_CHANNELS.
  - s_axis_tready[k] = (state==RUN) && slot_free && (k==grant). The value is combinational, but no tready depends on its own channel's tvalid except through the grant.
  - On acceptance: pointer <= grant+1 (wraps N_CHANNELS-1 -> 0); m_axis_tid <= grant.
  - No requests: pointer unchanged, tready all 0.
- FSM:
  - RUN -> DRAIN when reload_req=1 at a clock edge (subject to the lock rule under PKT_LOCK_EN). A beat accepted on that same edge completes normally.
  - DRAIN: all tready = 0. Wait until m_axis_tvalid==0, then count DRAIN_CYCLES cycles; the counter restarts if tvalid reasserts, which cannot occur. -> LOAD.
  - LOAD: shadow_rd_addr steps 0..HALF_N-1, one per cycle. coeff_wr_en=1 one cycle later, with coeff_wr_addr = the previous read address and coeff_wr_data = shadow_rd_data. LOAD lasts HALF_N+1 cycles. After the final write (addr HALF_N-1): reload_done=1 for one cycle -> RUN.
  - reload_req is sampled only in RUN; it is ignored in DRAIN/LOAD. If it is still high on return to RUN, a new reload starts (level-sensitive).
- Reset mid-LOAD: coeff_wr_en drops immediately (asynchronous). Already-written coefficients stay in the filter; the requester must reassert reload_req.
- Arbitration is fair: a continuously requesting channel waits at most N_CHANNELS-1 accepted beats.

Optional Feature:
PKT_LOCK_EN. When defined, the grant locks to a channel from its first accepted beat until its tlast beat is accepted, so packets are never interleaved. While locked, the other channels get tready=0. A RUN->DRAIN transition waits until the lock is released; reload_req stays pending. When undefined, arbitration is per beat and tlast is only forwarded.

Test Plan:
- Channels 0-3 all valid, tdata k*0x100+n, m_axis_tready=1 -> m_axis_tid sequence 0,1,2,3,0,... one beat per cycle; first m_axis_tvalid 1 cycle after the first acceptance.
- Only ch2 valid, then ch1 joins -> grants 2,1,2,1 (pointer wraps through 3,0).
- m_axis_tready=0 for 5 cycles with ch0 valid -> m_axis_tdata held, s_axis_tready all 0; one more beat accepted on the first ready cycle.
- reload_req pulse during traffic, shadow holds 0x0100+i -> tready drops; 12 idle cycles after the output empties; 16 writes addr 0..15 with data 0x0100..0x010F; reload_done pulse; traffic resumes with pointer preserved.
- aresetn low at LOAD write 7 -> coeff_wr_en=0 immediately; state RUN, outputs at reset values.
- PKT_LOCK_EN: ch0 4-beat packet with ch1 valid throughout -> tid 0,0,0,0 then 1; reload_req at beat 2 -> DRAIN entered only after ch0's tlast beat.

Source files
------------

// File: rtl/fir_channel_scheduler.sv
// fir_channel_scheduler: front end for the multi-channel symmetric FIR.
// Merges N_CHANNELS AXI-Stream sources into one tid-tagged stream through a
// round-robin arbiter and one output register. A coefficient-reload sequencer
// stalls input, drains the filter and then copies HALF_N words from the
// shadow bank into the filter's coefficient write port.
// Optional build macro: PKT_LOCK_EN keeps a granted channel until its tlast
// beat is accepted, so packets are never interleaved.
module fir_channel_scheduler #(
    parameter int N_CHANNELS       = 4,
    parameter int DATA_WIDTH       = 16,
    parameter int HALF_N           = 16,
    parameter int TID_WIDTH        = $clog2(N_CHANNELS),
    parameter int COEFF_WIDTH      = 16,
    parameter int COEFF_ADDR_WIDTH = $clog2(HALF_N),
    parameter int DRAIN_CYCLES     = 12
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [N_CHANNELS-1:0]            s_axis_tvalid,
    output logic [N_CHANNELS-1:0]            s_axis_tready,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_CHANNELS-1:0]            s_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [TID_WIDTH-1:0]             m_axis_tid,
    output logic                             m_axis_tlast,
    input  logic                             reload_req,
    output logic                             reload_done,
    output logic [COEFF_ADDR_WIDTH-1:0]      shadow_rd_addr,
    input  logic [COEFF_WIDTH-1:0]           shadow_rd_data,
    output logic                             coeff_wr_en,
    output logic [COEFF_ADDR_WIDTH-1:0]      coeff_wr_addr,
    output logic [COEFF_WIDTH-1:0]           coeff_wr_data,
    output logic [1:0]                       sched_state
);

    localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam int LCNT_W = $clog2(HALF_N + 1);

    localparam logic [TID_WIDTH:0]   NCH        = (TID_WIDTH+1)'(N_CHANNELS);
    localparam logic [TID_WIDTH-1:0] LAST_CH    = TID_WIDTH'(N_CHANNELS - 1);
    localparam logic [DCNT_W-1:0]    DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);
    localparam logic [LCNT_W-1:0]    LOAD_LAST  = LCNT_W'(HALF_N);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_LOAD  = 2'b10
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [TID_WIDTH-1:0]        r_ptr;
    logic                        r_tvalid;
    logic [DATA_WIDTH-1:0]       r_tdata;
    logic [TID_WIDTH-1:0]        r_tid;
    logic                        r_tlast;

    logic [DCNT_W-1:0]           r_drain_cnt;
    logic [LCNT_W-1:0]           r_load_cnt;
    logic                        r_wr_en;
    logic [COEFF_ADDR_WIDTH-1:0] r_wr_addr;
    logic                        r_done;

    logic [TID_WIDTH-1:0]        w_rr_grant;
    logic                        w_rr_any;
    logic [TID_WIDTH-1:0]        w_grant;
    logic                        w_any;
    logic                        w_slot_free;
    logic                        w_accept;
    logic [N_CHANNELS-1:0]       w_tready;
    logic [DATA_WIDTH-1:0]       w_gdata;
    logic                        w_glast;
    logic                        w_gvalid_lock;
    logic                        w_release;
    logic [COEFF_ADDR_WIDTH-1:0] w_rd_addr;

`ifdef PKT_LOCK_EN
    logic                        r_locked;
    logic [TID_WIDTH-1:0]        r_lock_ch;
`endif

    // Round-robin search: first requesting channel at or above the pointer, wrapping.
    always_comb begin
        logic [TID_WIDTH:0] w_sum;
        w_rr_grant = '0;
        w_rr_any   = 1'b0;
        w_sum      = '0;
        for (int i = N_CHANNELS - 1; i >= 0; i--) begin
            w_sum = {1'b0, r_ptr} + (TID_WIDTH+1)'(i);
            if (w_sum >= NCH) w_sum = w_sum - NCH;
            if (s_axis_tvalid[w_sum[TID_WIDTH-1:0]]) begin
                w_rr_any   = 1'b1;
                w_rr_grant = w_sum[TID_WIDTH-1:0];
            end
        end
    end

    // Valid bit of the locked channel, selected without a variable-width index.
    always_comb begin
        w_gvalid_lock = 1'b0;
        for (int k = 0; k < N_CHANNELS; k++) begin
`ifdef PKT_LOCK_EN
            if (r_lock_ch == TID_WIDTH'(k)) w_gvalid_lock = s_axis_tvalid[k];
`else
            w_gvalid_lock = 1'b0;
`endif
        end
    end

    // Final grant: a held packet lock overrides the round-robin choice.
`ifdef PKT_LOCK_EN
    assign w_grant   = r_locked ? r_lock_ch : w_rr_grant;
    assign w_any     = r_locked ? w_gvalid_lock : w_rr_any;
    // A reload may start only once no packet is open after this edge.
    assign w_release = !r_locked || (w_accept && w_glast);
`else
    assign w_grant   = w_rr_grant;
    assign w_any     = w_rr_any | (w_gvalid_lock & 1'b0);
    assign w_release = 1'b1;
`endif

    assign w_slot_free = !r_tvalid || m_axis_tready;
    assign w_accept    = (r_state == ST_RUN) && w_slot_free && w_any;

    // Per-channel ready and the granted channel's data/last, one-hot by grant.
    always_comb begin
        w_tready = '0;
        w_gdata  = '0;
        w_glast  = 1'b0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            if (w_grant == TID_WIDTH'(k)) begin
                w_tready[k] = (r_state == ST_RUN) && w_slot_free && w_any;
                w_gdata     = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
                w_glast     = s_axis_tlast[k];
            end
        end
    end

    // Output register; the pointer moves past the winner on every accepted beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tid    <= '0;
            r_tlast  <= 1'b0;
            r_ptr    <= '0;
        end else begin
            if (w_accept) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_gdata;
                r_tid    <= w_grant;
                r_tlast  <= w_glast;
                r_ptr    <= (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
            end else if (m_axis_tready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

`ifdef PKT_LOCK_EN
    // Packet lock: set by a non-last beat, released by the tlast beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_locked  <= 1'b0;
            r_lock_ch <= '0;
        end else if (w_accept) begin
            r_locked  <= !w_glast;
            r_lock_ch <= w_grant;
        end
    end
`endif

    // Scheduler state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= ST_RUN;
        else          r_state <= w_state_nxt;
    end

    // Next state: reload_req is only looked at in RUN, so it behaves as a level.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (reload_req && w_release) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!r_tvalid && r_drain_cnt == DRAIN_LAST) w_state_nxt = ST_LOAD;
            ST_LOAD:  if (r_load_cnt == LOAD_LAST) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Drain timer counts idle cycles once the output register is empty.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                  r_drain_cnt <= '0;
        else if (r_state != ST_DRAIN)  r_drain_cnt <= '0;
        else if (r_tvalid)             r_drain_cnt <= '0;
        else                           r_drain_cnt <= r_drain_cnt + 1'b1;
    end

    // Read address is the load cycle count while reads are still outstanding.
    assign w_rd_addr = ((r_state == ST_LOAD) && (r_load_cnt < LOAD_LAST))
                     ? r_load_cnt[COEFF_ADDR_WIDTH-1:0] : '0;

    // Load sequencer: a write trails each read by the shadow bank's one-cycle latency.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_load_cnt <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= (r_state == ST_LOAD) && (r_load_cnt == LOAD_LAST);
            if (r_state == ST_LOAD && r_load_cnt != LOAD_LAST) begin
                r_load_cnt <= r_load_cnt + 1'b1;
                r_wr_en    <= 1'b1;
                r_wr_addr  <= w_rd_addr;
            end else begin
                r_load_cnt <= '0;
                r_wr_en    <= 1'b0;
                r_wr_addr  <= '0;
            end
        end
    end

    assign s_axis_tready  = w_tready;
    assign m_axis_tvalid  = r_tvalid;
    assign m_axis_tdata   = r_tdata;
    assign m_axis_tid     = r_tid;
    assign m_axis_tlast   = r_tlast;
    assign reload_done    = r_done;
    assign shadow_rd_addr = w_rd_addr;
    assign coeff_wr_en    = r_wr_en;
    assign coeff_wr_addr  = r_wr_addr;
    assign coeff_wr_data  = r_wr_en ? shadow_rd_data : '0;
    assign sched_state    = r_state;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: a vector table for arbitration and
// backpressure, plus hand sequences for reload, reset during load and packet lock.
module tb_fir_channel_scheduler;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  s_axis_tvalid;
    logic [3:0]  s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic [3:0]  s_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [15:0] m_axis_tdata;
    logic [1:0]  m_axis_tid;
    logic        m_axis_tlast;
    logic        reload_req;
    logic        reload_done;
    logic [3:0]  shadow_rd_addr;
    logic [15:0] shadow_rd_data = 16'h0;
    logic        coeff_wr_en;
    logic [3:0]  coeff_wr_addr;
    logic [15:0] coeff_wr_data;
    logic [1:0]  sched_state;

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    fir_channel_scheduler dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tid(m_axis_tid), .m_axis_tlast(m_axis_tlast),
        .reload_req(reload_req), .reload_done(reload_done),
        .shadow_rd_addr(shadow_rd_addr), .shadow_rd_data(shadow_rd_data),
        .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr),
        .coeff_wr_data(coeff_wr_data), .sched_state(sched_state)
    );

    // Shadow bank: word i holds 0x0100+i, one-cycle read latency.
    always @(posedge aclk) shadow_rd_data <= 16'h0100 + {12'h000, shadow_rd_addr};

    typedef struct packed {
        logic [3:0]  tv;
        logic        rdy;
        logic [3:0]  last;
        logic [3:0]  exp_rdy;
        logic        exp_vld;
        logic [1:0]  exp_tid;
        logic [15:0] exp_data;
        logic        exp_last;
    } vec_t;

    vec_t vecs [19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Channel k carries k*0x100 + n.
    task automatic set_data(input int n);
        for (int k = 0; k < 4; k++) s_axis_tdata[k*16 +: 16] = 16'(k*256 + n);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn       = 1'b0;
        s_axis_tvalid = 4'h0;
        s_axis_tlast  = 4'h0;
        reload_req    = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        int   idle, load_cyc, nwr, stray;
        logic got_done, hit;

        s_axis_tvalid = 4'h0;
        s_axis_tlast  = 4'h0;
        s_axis_tdata  = 64'h0;
        m_axis_tready = 1'b0;
        reload_req    = 1'b0;

        vecs[0]  = '{4'hF, 1'b1, 4'hF, 4'b0001, 1'b1, 2'd0, 16'h0000, 1'b1};
        vecs[1]  = '{4'hF, 1'b1, 4'hF, 4'b0010, 1'b1, 2'd1, 16'h0101, 1'b1};
        vecs[2]  = '{4'hF, 1'b1, 4'hF, 4'b0100, 1'b1, 2'd2, 16'h0202, 1'b1};
        vecs[3]  = '{4'hF, 1'b1, 4'hF, 4'b1000, 1'b1, 2'd3, 16'h0303, 1'b1};
        vecs[4]  = '{4'hF, 1'b1, 4'hF, 4'b0001, 1'b1, 2'd0, 16'h0004, 1'b1};
        vecs[5]  = '{4'h4, 1'b1, 4'hF, 4'b0100, 1'b1, 2'd2, 16'h0205, 1'b1};
        vecs[6]  = '{4'h6, 1'b1, 4'hF, 4'b0010, 1'b1, 2'd1, 16'h0106, 1'b1};
        vecs[7]  = '{4'h6, 1'b1, 4'hF, 4'b0100, 1'b1, 2'd2, 16'h0207, 1'b1};
        vecs[8]  = '{4'h6, 1'b1, 4'hF, 4'b0010, 1'b1, 2'd1, 16'h0108, 1'b1};
        for (int i = 9; i < 14; i++)
            vecs[i] = '{4'h1, 1'b0, 4'hF, 4'b0000, 1'b1, 2'd1, 16'h0108, 1'b1};
        vecs[14] = '{4'h1, 1'b1, 4'hF, 4'b0001, 1'b1, 2'd0, 16'h000E, 1'b1};
        vecs[15] = '{4'h0, 1'b1, 4'hF, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b0};
        vecs[16] = '{4'h0, 1'b0, 4'hF, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b0};
        vecs[17] = '{4'hF, 1'b1, 4'hF, 4'b0010, 1'b1, 2'd1, 16'h0111, 1'b1};
        vecs[18] = '{4'h4, 1'b1, 4'h0, 4'b0100, 1'b1, 2'd2, 16'h0212, 1'b0};

        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst_tready", 32'(s_axis_tready), 32'h0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
        chk("rst_tdata", 32'(m_axis_tdata), 32'h0);
        chk("rst_tid", 32'(m_axis_tid), 32'h0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'h0);
        chk("rst_done", 32'(reload_done), 32'h0);
        chk("rst_wr_en", 32'(coeff_wr_en), 32'h0);
        chk("rst_wr_addr", 32'(coeff_wr_addr), 32'h0);
        chk("rst_rd_addr", 32'(shadow_rd_addr), 32'h0);
        chk("rst_state", 32'(sched_state), 32'h0);
        aresetn = 1'b1;

        // Arbitration / backpressure table
        for (int n = 0; n < 19; n++) begin
            @(negedge aclk);
            s_axis_tvalid = vecs[n].tv;
            m_axis_tready = vecs[n].rdy;
            s_axis_tlast  = vecs[n].last;
            set_data(n);
            #1;
            chk($sformatf("v%0d_tready", n), 32'(s_axis_tready), 32'(vecs[n].exp_rdy));
            @(posedge aclk);
            #1;
            chk($sformatf("v%0d_tvalid", n), 32'(m_axis_tvalid), 32'(vecs[n].exp_vld));
            if (vecs[n].exp_vld) begin
                chk($sformatf("v%0d_tid", n), 32'(m_axis_tid), 32'(vecs[n].exp_tid));
                chk($sformatf("v%0d_tdata", n), 32'(m_axis_tdata), 32'(vecs[n].exp_data));
                chk($sformatf("v%0d_tlast", n), 32'(m_axis_tlast), 32'(vecs[n].exp_last));
            end
        end

        // Coefficient reload during traffic
        do_reset();
        s_axis_tvalid = 4'hF;
        s_axis_tlast  = 4'hF;
        set_data(0);
        m_axis_tready = 1'b1;
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        reload_req = 1'b1;
        idle = 0; load_cyc = 0; nwr = 0; stray = 0; got_done = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge aclk);
            if (cyc == 0) begin
                chk("drain_entry", 32'(sched_state), 32'h1);
                chk("drain_last_tid", 32'(m_axis_tid), 32'h2);
                reload_req = 1'b0;
            end
            if (sched_state != 2'b00 && s_axis_tready != 4'h0) stray++;
            if (sched_state == 2'b01 && !m_axis_tvalid) idle++;
            if (sched_state == 2'b10) load_cyc++;
            if (coeff_wr_en) begin
                chk($sformatf("wr%0d_addr", nwr), 32'(coeff_wr_addr), 32'(nwr));
                chk($sformatf("wr%0d_data", nwr), 32'(coeff_wr_data), 32'(16'h0100 + nwr));
                nwr++;
            end
            if (reload_done) begin
                got_done = 1'b1;
                chk("resume_tready", 32'(s_axis_tready), 32'h8);
                chk("done_state", 32'(sched_state), 32'h0);
                chk("done_tvalid", 32'(m_axis_tvalid), 32'h0);
                break;
            end
        end
        chk("reload_done_seen", 32'(got_done), 32'h1);
        chk("drain_idle_cycles", 32'(idle), 32'd12);
        chk("load_cycles", 32'(load_cyc), 32'd17);
        chk("write_count", 32'(nwr), 32'd16);
        chk("stall_tready", 32'(stray), 32'd0);
        @(posedge aclk);
        #1;
        chk("resume_tvalid", 32'(m_axis_tvalid), 32'h1);
        chk("resume_tid", 32'(m_axis_tid), 32'h3);
        @(negedge aclk);
        chk("done_single_pulse", 32'(reload_done), 32'h0);
        @(posedge aclk);
        #1;
        chk("resume_wrap_tid", 32'(m_axis_tid), 32'h0);

        // Reset asserted in the middle of LOAD
        do_reset();
        reload_req = 1'b1;
        hit = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge aclk);
            if (coeff_wr_en && coeff_wr_addr == 4'd7) begin
                hit = 1'b1;
                break;
            end
        end
        chk("load_write7_reached", 32'(hit), 32'h1);
        aresetn    = 1'b0;
        reload_req = 1'b0;
        #1;
        chk("midload_wr_en", 32'(coeff_wr_en), 32'h0);
        chk("midload_state", 32'(sched_state), 32'h0);
        chk("midload_rd_addr", 32'(shadow_rd_addr), 32'h0);
        chk("midload_wr_addr", 32'(coeff_wr_addr), 32'h0);
        chk("midload_tvalid", 32'(m_axis_tvalid), 32'h0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        chk("post_reset_state", 32'(sched_state), 32'h0);
        chk("post_reset_wr_en", 32'(coeff_wr_en), 32'h0);

`ifdef PKT_LOCK_EN
        // Packet lock: ch0 4-beat packet with ch1 requesting throughout
        do_reset();
        m_axis_tready = 1'b1;
        s_axis_tvalid = 4'b0011;
        for (int b = 0; b < 5; b++) begin
            @(negedge aclk);
            s_axis_tlast = (b == 3) ? 4'b0011 : 4'b0010;
            set_data(b);
            #1;
            chk($sformatf("lockA%0d_tready", b), 32'(s_axis_tready), (b < 4) ? 32'h1 : 32'h2);
            @(posedge aclk);
            #1;
            chk($sformatf("lockA%0d_tid", b), 32'(m_axis_tid), (b < 4) ? 32'h0 : 32'h1);
        end
        // Reload requested mid-packet waits for the tlast beat
        for (int b = 0; b < 4; b++) begin
            @(negedge aclk);
            s_axis_tlast = (b == 3) ? 4'b0011 : 4'b0010;
            if (b == 2) reload_req = 1'b1;
            #1;
            chk($sformatf("lockB%0d_state", b), 32'(sched_state), 32'h0);
            chk($sformatf("lockB%0d_tready", b), 32'(s_axis_tready), 32'h1);
            @(posedge aclk);
            #1;
            chk($sformatf("lockB%0d_tid", b), 32'(m_axis_tid), 32'h0);
        end
        @(negedge aclk);
        chk("lock_drain_state", 32'(sched_state), 32'h1);
        chk("lock_drain_tready", 32'(s_axis_tready), 32'h0);
        reload_req = 1'b0;
        got_done = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge aclk);
            if (reload_done) begin
                got_done = 1'b1;
                break;
            end
        end
        chk("lock_reload_done", 32'(got_done), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
